// File: rtl/seq_mul_wb.sv
// seq_mul_wb: multi-cycle WIDTH x WIDTH shift-add multiplier that writes
// the low half of the product back to the register file.
// Optional build macro: MUL_SIGNED_EN adds the signed_op input, which
// selects a signed (two's-complement) multiply.
module seq_mul_wb #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       dest,
`ifdef MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic [1:0]       wr_out,
  output logic             regwrite_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_dest;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [1:0]         r_wr;
  logic               r_regwrite;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_b_op;
  logic               w_last;
  logic               w_accept;

`ifdef MUL_SIGNED_EN
  logic r_neg;
`endif

  // One shift-add step: add the multiplicand into the upper half (keeping
  // the carry), then shift {carry, acc} right by one.
  always_comb begin
    if (r_mplier[0]) begin
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end else begin
      w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    end
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    w_last     = (r_count == CNT_W'(WIDTH - 1));
    w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  end

  // Operand conditioning at capture and final sign fix-up of the product.
  always_comb begin
`ifdef MUL_SIGNED_EN
    if (signed_op && a[WIDTH-1]) begin
      w_a_op = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_a_op = a;
    end
    if (signed_op && b[WIDTH-1]) begin
      w_b_op = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_b_op = b;
    end
    if (r_neg) begin
      w_prod = ~w_acc_next + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_prod = w_acc_next;
    end
`else
    w_a_op = a;
    w_b_op = b;
    w_prod = w_acc_next;
`endif
  end

`ifdef MUL_SIGNED_EN
  // Result sign is captured alongside the operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_neg <= 1'b0;
    end else if (w_accept) begin
      r_neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`endif

  // Control FSM, datapath iteration and registered write-back outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mcand    <= {WIDTH{1'b0}};
      r_mplier   <= {WIDTH{1'b0}};
      r_acc      <= {(2*WIDTH){1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_dest     <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lo       <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_wr       <= 2'd0;
      r_regwrite <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_regwrite <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_mcand  <= w_a_op;
            r_mplier <= w_b_op;
            r_dest   <= dest;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_lo       <= w_prod[WIDTH-1:0];
            r_hi       <= w_prod[2*WIDTH-1:WIDTH];
            r_wr       <= r_dest;
            r_regwrite <= (r_dest != 2'd0);
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign lo           = r_lo;
  assign hi           = r_hi;
  assign wr_out       = r_wr;
  assign regwrite_out = r_regwrite;

endmodule

// File: tb/tb_seq_mul_wb.sv
// Directed self-checking bench for seq_mul_wb.
module tb_seq_mul_wb;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  dest;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [1:0]  wr_out;
  logic        regwrite_out;

  int n_cmp;
  int n_bad;

  seq_mul_wb #(.WIDTH(16), .CNT_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .dest         (dest),
`ifdef MUL_SIGNED_EN
    .signed_op    (signed_op),
`endif
    .busy         (busy),
    .done         (done),
    .lo           (lo),
    .hi           (hi),
    .wr_out       (wr_out),
    .regwrite_out (regwrite_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; sample 1 time unit after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Full single operation: start in cycle 0, checks in cycles 1, 16, 17, 18.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [1:0] td, input logic ts,
                        input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                        input logic exp_rw);
    a = ta; b = tb; dest = td; signed_op = ts; start = 1'b1;
    step(1);
    start = 1'b0; a = 16'h0; b = 16'h0; dest = 2'd0; signed_op = 1'b0;
    check_eq({tag, " busy c1"}, {63'd0, busy}, 64'd1);
    step(15);
    check_eq({tag, " busy/done c16"}, {62'd0, busy, done}, 64'd2);
    step(1);
    check_eq({tag, " busy/done c17"}, {62'd0, busy, done}, 64'd1);
    check_eq({tag, " product c17"}, {32'd0, hi, lo}, {32'd0, exp_hi, exp_lo});
    check_eq({tag, " wr_out c17"}, {62'd0, wr_out}, {62'd0, td});
    check_eq({tag, " regwrite c17"}, {63'd0, regwrite_out}, {63'd0, exp_rw});
    step(1);
    check_eq({tag, " done/rw c18"}, {62'd0, done, regwrite_out}, 64'd0);
    check_eq({tag, " lo hold c18"}, {48'd0, lo}, {48'd0, exp_lo});
  endtask

  int done_cnt;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; dest = 2'd0; signed_op = 1'b0;

    // 1. reset held two cycles, then idle outputs stay zero
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_eq("idle outputs", {42'd0, busy, done, lo, hi, wr_out, regwrite_out}, 64'd0);
    end

    // 2-4. basic products
    run_op("3x5",       16'd3,    16'd5,    2'd1, 1'b0, 16'd15,   16'd0,    1'b1);
    run_op("FFFFxFFFF", 16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 16'h0001, 16'hFFFE, 1'b1);
    run_op("7x9 r0",    16'd7,    16'd9,    2'd0, 1'b0, 16'd63,   16'd0,    1'b0);
    run_op("1234x10",   16'h1234, 16'h0010, 2'd2, 1'b0, 16'h2340, 16'h0001, 1'b1);

    // 5. start ignored during RUN, accepted back-to-back in DONE
    a = 16'd2; b = 16'd2; dest = 2'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    a = 16'd9; b = 16'd9; dest = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(11);
    check_eq("b2b first done", {63'd0, done}, 64'd1);
    check_eq("b2b first lo", {48'd0, lo}, 64'd4);
    check_eq("b2b first wr", {62'd0, wr_out}, 64'd2);
    a = 16'd10; b = 16'd10; dest = 2'd3; start = 1'b1;
    step(1);
    start = 1'b0;
    check_eq("b2b second busy", {62'd0, busy, done}, 64'd2);
    check_eq("b2b lo held", {48'd0, lo}, 64'd4);
    step(16);
    check_eq("b2b second done", {63'd0, done}, 64'd1);
    check_eq("b2b second lo", {32'd0, hi, lo}, 64'd100);
    check_eq("b2b second wr", {62'd0, wr_out}, 64'd3);
    step(1);

    // 6. reset mid-run aborts with no done pulse
    a = 16'd100; b = 16'd100; dest = 2'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_eq("abort c9", {42'd0, busy, done, lo, hi, wr_out, regwrite_out}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (done) done_cnt++;
    end
    check_eq("abort no done", 64'(done_cnt), 64'd0);
    check_eq("abort outputs", {42'd0, busy, done, lo, hi, wr_out, regwrite_out}, 64'd0);

`ifdef MUL_SIGNED_EN
    run_op("s -3x5",    16'hFFFD, 16'd5,    2'd1, 1'b1, 16'hFFF1, 16'hFFFF, 1'b1);
    run_op("s -3x-5",   16'hFFFD, 16'hFFFB, 2'd2, 1'b1, 16'd15,   16'd0,    1'b1);
    run_op("s 8000x8000", 16'h8000, 16'h8000, 2'd3, 1'b1, 16'h0000, 16'h4000, 1'b1);
    run_op("u FFFDx5",  16'hFFFD, 16'd5,    2'd1, 1'b0, 16'hFFF1, 16'h0004, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
